ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Round-robin arbiter and access sequencer that lets NUM_REQ requesters share one single-port synchronous RAM. Typical requesters: processor core RAM path, ROM loader, debug port.
- Serialises requests into one-at-a-time RAM transactions of known latency. Returns a one-cycle ack pulse, and read data for reads, to the granted requester.
- Sits between the processor datapath and the RAM.

Parameters:
DATA_WIDTH, 16, width of RAM data word
ADDR_WIDTH, 8, width of RAM address
NUM_REQ, 4, number of requesters (2..8)
MEM_LATENCY, 1, cycles from mem_en cycle to valid mem_rdata (1..7)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
req_valid  input  NUM_REQ  per-requester request; held high until matching req_ack
req_write  input  NUM_REQ  per-requester: 1 = write, 0 = read
req_addr  input  NUM_REQ*ADDR_WIDTH  packed addresses; requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
req_wdata  input  NUM_REQ*DATA_WIDTH  packed write data; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
req_ack  output  NUM_REQ  one-hot, one-cycle completion pulse
rsp_data  output  DATA_WIDTH  read data; valid in the req_ack cycle of a read, held until the next read completes
mem_en  output  1  RAM access strobe, one cycle per transaction
mem_we  output  1  RAM write enable, qualified by mem_en
mem_addr  output  ADDR_WIDTH  RAM address
mem_wdata  output  DATA_WIDTH  RAM write data
mem_rdata  input  DATA_WIDTH  RAM read data
busy  output  1  high in every state except IDLE
grant_id  output  clog2(NUM_REQ)  index of the current or last granted requester

Behaviour:
- All outputs are registered or decoded from registered state. No combinational path from req_* to mem_*.
- Reset values: state IDLE, mem_en 0, mem_we 0, mem_addr 0, mem_wdata 0, req_ack 0, rsp_data 0, busy 0, grant_id 0, round-robin pointer last = NUM_REQ-1 (requester 0 wins first).
- States: IDLE, ISSUE, WAIT, DONE.
- IDLE, no req_valid bit set: stay in IDLE.
- IDLE, any req_valid bit set at edge T:
  - Winner is the first set bit scanning from last+1 upward, wrapping modulo NUM_REQ.
  - Latch winner's index, write flag, address and wdata; set last = winner.
  - Go to ISSUE.
- ISSUE (cycle T+1): mem_en=1, mem_addr/mem_wdata from latched fields, mem_we = latched write flag.
  - Write: go to DONE.
  - Read: go to WAIT and load counter with MEM_LATENCY.
- WAIT: mem_en=0; decrement the counter each cycle. On the edge where the counter reaches 1, capture mem_rdata into rsp_data and go to DONE. Reads spend exactly MEM_LATENCY cycles in WAIT.
- DONE: req_ack[grant_id]=1 for exactly this cycle, then go to IDLE.
- Latency from the sampling edge: write ack in cycle T+2; read ack in cycle T+2+MEM_LATENCY.
- Spacing between back-to-back transactions is 3 cycles for writes and 3+MEM_LATENCY for reads; the IDLE cycle is never skipped.
- Writes leave rsp_data unchanged.
- req_valid dropped mid-transaction: the transaction completes and still acks. The requester must not re-raise valid for the same request.
- req_valid still high in the DONE cycle: the arbiter re-samples it in the following IDLE cycle. The requester must drop valid on ack unless it has a new request.
- Requests that change their fields while pending are ignored after latching.
- Simultaneous requests: exactly one grant per IDLE cycle. With all NUM_REQ held, grants rotate 0,1,2,3,0,...
- Reset in any state: return to IDLE with reset values, no ack for the aborted transaction, pointer restored.

Optional Feature:
- Macro: RAM_PORT_ARBITER_FIXED_PRIORITY_EN.
- Defined: fixed priority; lowest set index always wins; pointer unused.
- Undefined: round-robin as above.
- All other timing is identical in both builds.

Test Plan:
1. Reset, then only requester 2 writes addr 0x10 data 0xBEEF -> mem_en/mem_we high in cycle T+1 with mem_addr 0x10, mem_wdata 0xBEEF; req_ack = 4'b0100 in cycle T+2; busy low again at T+3.
2. MEM_LATENCY=3, RAM model returning 0x1234 for addr 0x05; requester 1 reads 0x05 -> req_ack = 4'b0010 in cycle T+5 with rsp_data = 0x1234.
3. All four requesters hold writes continuously -> grant order 0,1,2,3,0. Fixed-priority build: requester 0 granted every transaction.
4. Requester 3 drops req_valid one cycle after grant -> transaction still issued; req_ack[3] still pulses; no second grant to 3.
5. Assert reset during WAIT of a read -> next cycle all outputs at reset values, no req_ack; next request from requester 0 and 1 together grants 0 first.
6. Read 0xAAAA then write -> rsp_data stays 0xAAAA through and after the write ack.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// ram_port_arbiter: shares one single-port synchronous RAM between NUM_REQ
// requesters. One transaction at a time: IDLE -> ISSUE -> (WAIT) -> DONE.
// Optional build macro RAM_PORT_ARBITER_FIXED_PRIORITY_EN selects fixed
// priority (lowest index wins) instead of round-robin.
module ram_port_arbiter #(
  parameter int DATA_WIDTH  = 16,
  parameter int ADDR_WIDTH  = 8,
  parameter int NUM_REQ     = 4,
  parameter int MEM_LATENCY = 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_write,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
  output logic [NUM_REQ-1:0]            req_ack,
  output logic [DATA_WIDTH-1:0]         rsp_data,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic                          busy,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id
);
  localparam int GW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

  state_t                state, state_nx;
  logic [GW-1:0]         pick;
  logic                  sel_write;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic                  wr_q;
  logic [2:0]            cnt;
`ifndef RAM_PORT_ARBITER_FIXED_PRIORITY_EN
  logic [GW-1:0]         last;
  logic [GW:0]           cand;
  logic                  found;
`endif

  // Winner selection and mux of the winner's request fields.
  always_comb begin
    pick = '0;
`ifdef RAM_PORT_ARBITER_FIXED_PRIORITY_EN
    for (int i = NUM_REQ-1; i >= 0; i--)
      if (|(req_valid & (NUM_REQ'(1) << i))) pick = GW'(i);
`else
    found = 1'b0;
    cand  = '0;
    // Scan last+1, last+2, ... wrapping; first set bit wins.
    for (int k = 1; k <= NUM_REQ; k++) begin
      cand = {1'b0, last} + (GW+1)'(k);
      if (cand >= (GW+1)'(NUM_REQ)) cand = cand - (GW+1)'(NUM_REQ);
      if (!found && |(req_valid & (NUM_REQ'(1) << cand))) begin
        found = 1'b1;
        pick  = cand[GW-1:0];
      end
    end
`endif
    sel_write = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (pick == GW'(i)) begin
        sel_write = req_write[i];
        sel_addr  = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        sel_wdata = req_wdata[i*DATA_WIDTH +: DATA_WIDTH];
      end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  // Next-state logic; IDLE is always visited between transactions.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:  if (|req_valid) state_nx = S_ISSUE;
      S_ISSUE: state_nx = wr_q ? S_DONE : S_WAIT;
      S_WAIT:  if (cnt == 3'd1) state_nx = S_DONE;
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  // Request latch, grant pointer, latency counter and read-data capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      grant_id  <= '0;
      wr_q      <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      cnt       <= '0;
      rsp_data  <= '0;
`ifndef RAM_PORT_ARBITER_FIXED_PRIORITY_EN
      last      <= GW'(NUM_REQ-1);
`endif
    end else begin
      case (state)
        S_IDLE: if (|req_valid) begin
          grant_id  <= pick;
          wr_q      <= sel_write;
          mem_addr  <= sel_addr;
          mem_wdata <= sel_wdata;
`ifndef RAM_PORT_ARBITER_FIXED_PRIORITY_EN
          last      <= pick;
`endif
        end
        S_ISSUE: cnt <= 3'(MEM_LATENCY);
        S_WAIT: begin
          cnt <= cnt - 3'd1;
          if (cnt == 3'd1) rsp_data <= mem_rdata;
        end
        default: ;
      endcase
    end
  end

  // Outputs decoded from registered state only.
  always_comb begin
    mem_en  = (state == S_ISSUE);
    mem_we  = (state == S_ISSUE) && wr_q;
    busy    = (state != S_IDLE);
    req_ack = '0;
    if (state == S_DONE) req_ack = NUM_REQ'(1) << grant_id;
  end

endmodule
